// File: rtl/adc_sample_scheduler_pkg.sv
// Shared constants, state encoding and sample conversion helper for the ADC sample scheduler.
package adc_sample_scheduler_pkg;

    localparam int ADC_W           = 10;
    localparam int ADC_OFFSET      = 512;
    localparam int DEF_CLK_FREQ    = 27_000_000;
    localparam int DEF_SAMPLE_RATE = 45_000;
    localparam int DEF_FRAME_LEN   = 64;
    localparam int DEF_TIMEOUT     = 1023;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_CONVERT   = 2'd2,
        S_WAIT_TICK = 2'd3
    } sched_state_t;

    // Mid-scale offset removal; for a 10-bit result this is the same as inverting the MSB.
    function automatic logic [ADC_W-1:0] to_signed_sample(input logic [ADC_W-1:0] raw);
        return raw - ADC_W'(ADC_OFFSET);
    endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Conversion request / result handshake between the scheduler (master) and the MCP3002 driver (slave).
interface adc_sample_scheduler_if;
    import adc_sample_scheduler_pkg::*;

    logic             adc_enable;
    logic             adc_clear_available;
    logic             adc_available;
    logic [ADC_W-1:0] adc_data;

    modport master (
        output adc_enable,
        output adc_clear_available,
        input  adc_available,
        input  adc_data
    );

    modport slave (
        input  adc_enable,
        input  adc_clear_available,
        output adc_available,
        output adc_data
    );

endinterface

// File: rtl/adc_sample_scheduler_sample_tick_gen.sv
// Sample-period counter: free-runs while enabled, restarts on clear, one-cycle tick on the last count.
module sample_tick_gen #(
    parameter int PERIOD = 600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             last_count;

    assign last_count = (cnt_reg == CNT_W'(PERIOD - 1));
    assign tick       = enable && last_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= last_count ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodically requests MCP3002 conversions, handles the available/clear handshake and streams
// offset-removed samples with a frame index, plus sticky overrun and timeout flags.
module adc_sample_scheduler
    import adc_sample_scheduler_pkg::*;
#(
    parameter int CLK_FREQ    = DEF_CLK_FREQ,
    parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
    parameter int FRAME_LEN   = DEF_FRAME_LEN,
    parameter int IDX_W       = 6,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    output logic                          busy,
    adc_sample_scheduler_if.master        adc,
    output logic                          sample_valid,
    output logic [ADC_W-1:0]              sample_data,
    output logic [IDX_W-1:0]              sample_idx,
    output logic                          frame_done,
    output logic                          overrun,
    output logic                          timeout_err,
    input  logic                          err_clear
);

    localparam int PERIOD = CLK_FREQ / SAMPLE_RATE;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    sched_state_t     state_reg, state_next;
    logic             busy_reg;
    logic             stop_pending_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             sample_valid_reg;
    logic             frame_done_reg;
    logic [ADC_W-1:0] sample_data_reg;
    logic [IDX_W-1:0] sample_idx_reg;
    logic             overrun_reg;
    logic             timeout_err_reg;

    logic tick;
    logic start_accept;
    logic capture;
    logic timeout_hit;
    logic overrun_set;
    logic stop_seen;

    sample_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (busy_reg),
        .clear  (start_accept),
        .tick   (tick)
    );

    assign stop_seen   = stop_pending_reg | stop;
    assign overrun_set = tick && ((state_reg == S_REQ) || (state_reg == S_CONVERT));

    always_comb begin
        state_next              = state_reg;
        start_accept            = 1'b0;
        capture                 = 1'b0;
        timeout_hit             = 1'b0;
        adc.adc_enable          = 1'b0;
        adc.adc_clear_available = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start && !stop) begin
                    start_accept = 1'b1;
                    state_next   = S_REQ;
                end
            end
            // The driver's flag may still be stale here, so it is cleared rather than sampled.
            S_REQ: begin
                adc.adc_enable          = 1'b1;
                adc.adc_clear_available = 1'b1;
                state_next              = S_CONVERT;
            end
            S_CONVERT: begin
                if (adc.adc_available) begin
                    capture                 = 1'b1;
                    adc.adc_clear_available = 1'b1;
                    state_next              = stop_seen ? S_IDLE : S_WAIT_TICK;
                end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_WAIT_TICK: begin
                if (stop_seen) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            busy_reg         <= 1'b0;
            stop_pending_reg <= 1'b0;
            tmo_cnt_reg      <= '0;
            sample_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            sample_data_reg  <= '0;
            sample_idx_reg   <= '0;
            overrun_reg      <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != S_IDLE);

            if (start_accept || (state_next == S_IDLE)) begin
                stop_pending_reg <= 1'b0;
            end else if (stop) begin
                stop_pending_reg <= 1'b1;
            end

            if (state_reg == S_REQ) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == S_CONVERT) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end

            sample_valid_reg <= capture;
            frame_done_reg   <= capture && (sample_idx_reg == IDX_W'(FRAME_LEN - 1));
            if (capture) begin
                sample_data_reg <= to_signed_sample(adc.adc_data);
            end

            // Index advances once the sample carrying it has been presented.
            if (start_accept) begin
                sample_idx_reg <= '0;
            end else if (sample_valid_reg) begin
                sample_idx_reg <= sample_idx_reg + 1'b1;
            end

            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (err_clear) begin
                overrun_reg <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clear) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign busy         = busy_reg;
    assign sample_valid = sample_valid_reg;
    assign sample_data  = sample_data_reg;
    assign sample_idx   = sample_idx_reg;
    assign frame_done   = frame_done_reg;
    assign overrun      = overrun_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench: two schedulers (600- and 100-cycle sample periods) driven by a behavioural ADC driver model.
module tb_adc_sample_scheduler;
    import adc_sample_scheduler_pkg::*;

    localparam int NI = 2;

    typedef struct {
        logic [9:0] adc;
        logic [9:0] exp;
    } vec_t;

    vec_t vtab[8];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] start     = '0;
    logic [1:0] stop      = '0;
    logic [1:0] err_clear = '0;
    logic [1:0] busy, sv, fd, ovr, tmo, en, clr;
    logic [1:0][9:0] sd;
    logic [1:0][5:0] sidx;

    int lat[NI];
    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int req_n[NI];
    int exp_idx[NI];
    logic [15:0] sbq0[$];
    logic [15:0] sbq1[$];

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [9:0] model_adc(input int n);
        logic [31:0] h;
        if (n < 8) return vtab[n].adc;
        h = n * 229 + 77;
        return h[9:0];
    endfunction

    function automatic logic [9:0] expect_sample(input int n);
        int v;
        if (n < 8) return vtab[n].exp;
        v = int'(model_adc(n)) - 512;
        return v[9:0];
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        adc_sample_scheduler_if bus ();
        logic       avail_r;
        logic [9:0] data_r;
        int         cnt_r;
        int         nreq_r;

        assign bus.adc_available = avail_r;
        assign bus.adc_data      = data_r;
        assign en[gi]            = bus.adc_enable;
        assign clr[gi]           = bus.adc_clear_available;

        // Driver model: flag powers up stale-high, result appears lat cycles after a request.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                avail_r <= 1'b1;
                data_r  <= '0;
                cnt_r   <= 0;
                nreq_r  <= 0;
            end else begin
                if (bus.adc_clear_available) avail_r <= 1'b0;
                if (bus.adc_enable) begin
                    cnt_r  <= lat[gi];
                    nreq_r <= nreq_r + 1;
                end else if (cnt_r > 0) begin
                    cnt_r <= cnt_r - 1;
                end
                if (!bus.adc_enable && cnt_r == 1) begin
                    avail_r <= 1'b1;
                    data_r  <= model_adc(nreq_r - 1);
                end
            end
        end

        adc_sample_scheduler #(
            .CLK_FREQ    (27_000_000),
            .SAMPLE_RATE ((gi == 0) ? 45_000 : 270_000)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start[gi]),
            .stop         (stop[gi]),
            .busy         (busy[gi]),
            .adc          (bus),
            .sample_valid (sv[gi]),
            .sample_data  (sd[gi]),
            .sample_idx   (sidx[gi]),
            .frame_done   (fd[gi]),
            .overrun      (ovr[gi]),
            .timeout_err  (tmo[gi]),
            .err_clear    (err_clear[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic monitor();
        for (int g = 0; g < NI; g++) begin
            if (en[g]) begin
                if (lat[g] > 0) begin
                    logic [15:0] e;
                    e = {exp_idx[g][5:0], expect_sample(req_n[g])};
                    if (g == 0) sbq0.push_back(e);
                    else        sbq1.push_back(e);
                    exp_idx[g]++;
                end
                req_n[g]++;
            end
            if (sv[g]) begin
                logic [15:0] e;
                int          have;
                have = (g == 0) ? sbq0.size() : sbq1.size();
                nvec++;
                if (have == 0) begin
                    nfail++;
                    $display("FAIL unexpected_sample inst%0d: got data=%h idx=%0d, required no sample",
                             g, sd[g], sidx[g]);
                end else begin
                    if (g == 0) e = sbq0.pop_front();
                    else        e = sbq1.pop_front();
                    if ({sidx[g], sd[g], fd[g]} !== {e, (e[15:10] == 6'd63)}) begin
                        nfail++;
                        $display("FAIL sample inst%0d: got data=%h idx=%0d fd=%0d, required data=%h idx=%0d fd=%0d",
                                 g, sd[g], sidx[g], fd[g], e[9:0], e[15:10], (e[15:10] == 6'd63));
                    end
                end
            end else if (fd[g]) begin
                nvec++;
                nfail++;
                $display("FAIL stray_frame_done inst%0d: got 1 without sample_valid, required 0", g);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = '0;
        stop      = '0;
        err_clear = '0;
        run(2);
        sbq0.delete();
        sbq1.delete();
        for (int g = 0; g < NI; g++) begin
            req_n[g]   = 0;
            exp_idx[g] = 0;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start(input int g, input logic with_stop);
        start[g] = 1'b1;
        stop[g]  = with_stop;
        if (!with_stop) exp_idx[g] = 0;
        step();
        start[g] = 1'b0;
        stop[g]  = 1'b0;
    endtask

    task automatic pulse_stop(input int g);
        stop[g] = 1'b1;
        step();
        stop[g] = 1'b0;
    endtask

    task automatic pulse_clear(input int g);
        err_clear[g] = 1'b1;
        step();
        err_clear[g] = 1'b0;
    endtask

    task automatic wait_sv(input int g, input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            seen = sv[g];
        end
        if (!seen) begin
            nvec++;
            nfail++;
            $display("FAIL %s: no sample_valid within %0d cycles, required one", name, limit);
        end
    endtask

    task automatic wait_en(input int g, input int limit, input string name, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            step();
            if (en[g]) at = cyc;
        end
        if (at < 0) begin
            nvec++;
            nfail++;
            $display("FAIL %s: no adc_enable within %0d cycles, required one", name, limit);
        end
    endtask

    task automatic wait_idle(input int g, input int limit, input string name);
        for (int i = 0; i < limit && busy[g]; i++) step();
        check(name, busy[g], 0);
    endtask

    initial begin
        int  prev, at, r0, r2, nbefore, fd_n, fd_a, fd_b;
        bit  any_nz;

        vtab[0] = '{10'h3FF, 10'h1FF};
        vtab[1] = '{10'h200, 10'h000};
        vtab[2] = '{10'h000, 10'h200};
        vtab[3] = '{10'h001, 10'h201};
        vtab[4] = '{10'h1FF, 10'h3FF};
        vtab[5] = '{10'h201, 10'h001};
        vtab[6] = '{10'h155, 10'h355};
        vtab[7] = '{10'h2AA, 10'h0AA};
        lat[0] = 100;
        lat[1] = 20;

        do_reset();
        check("reset_ctrl", {18'd0, busy, sv, fd, ovr, tmo, en, clr}, 0);
        check("reset_data", {sd, sidx}, 0);

        // Idle with no start: nothing may move.
        any_nz = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (|{busy, sv, fd, ovr, tmo, en, clr, sd, sidx}) any_nz = 1'b1;
        end
        check("idle_quiet", any_nz, 0);
        check("idle_no_request", req_n[0] + req_n[1], 0);

        // Table-driven conversions on the 600-cycle instance.
        pulse_start(0, 1'b0);
        check("first_request", en[0], 1);
        check("busy_after_start", busy[0], 1);
        prev = cyc;
        for (int i = 0; i < 8; i++) begin
            wait_sv(0, 700, "table_sample_wait");
            check("table_sample", sd[0], vtab[i].exp);
            if (i < 7) begin
                wait_en(0, 700, "table_request_wait", at);
                check("request_spacing", at - prev, 600);
                prev = at;
            end
        end
        pulse_stop(0);
        wait_idle(0, 700, "table_stop_idle");
        check("table_queue_drained", sbq0.size(), 0);

        // Frame wrap on the 100-cycle instance.
        fd_n = 0;
        fd_a = 0;
        fd_b = 0;
        pulse_start(1, 1'b0);
        for (int k = 0; k < 130; k++) begin
            wait_sv(1, 150, "wrap_sample_wait");
            check("wrap_idx", sidx[1], k % 64);
            if (fd[1]) begin
                fd_n++;
                if (fd_n == 1) fd_a = k + 1;
                if (fd_n == 2) fd_b = k + 1;
            end
        end
        check("frame_done_count", fd_n, 2);
        check("frame_done_first", fd_a, 64);
        check("frame_done_second", fd_b, 128);
        check("wrap_no_overrun", ovr[1], 0);
        pulse_stop(1);
        wait_idle(1, 200, "wrap_stop_idle");

        // Conversion slower than the sample period.
        lat[0] = 700;
        pulse_start(0, 1'b0);
        r0 = cyc;
        run(599);
        check("overrun_before_tick", ovr[0], 0);
        step();
        check("overrun_at_tick", ovr[0], 1);
        wait_sv(0, 150, "overrun_sample_wait");
        wait_en(0, 600, "overrun_request_wait", at);
        check("request_after_drop", at - r0, 1200);
        r2 = at;
        run(5);
        pulse_clear(0);
        check("overrun_cleared", ovr[0], 0);
        run(r2 + 599 - cyc);
        err_clear[0] = 1'b1;
        step();
        err_clear[0] = 1'b0;
        check("overrun_set_beats_clear", ovr[0], 1);
        pulse_clear(0);
        check("overrun_cleared_again", ovr[0], 0);
        pulse_stop(0);
        wait_sv(0, 150, "overrun_final_sample");
        check("overrun_stop_idle", busy[0], 0);
        check("overrun_queue_drained", sbq0.size(), 0);

        // Driver never answers.
        lat[0] = -1;
        pulse_start(0, 1'b0);
        r0 = cyc;
        run(1023);
        check("timeout_not_yet", {busy[0], tmo[0]}, 2'b10);
        step();
        check("timeout_flag", {busy[0], tmo[0]}, 2'b01);
        check("timeout_elapsed", cyc - r0, 1024);
        run(20);
        check("timeout_no_sample", sbq0.size(), 0);
        pulse_clear(0);
        check("timeout_cleared", tmo[0], 0);

        // Stop mid-conversion still delivers the in-flight sample.
        lat[0] = 100;
        pulse_start(0, 1'b0);
        run(30);
        pulse_stop(0);
        wait_sv(0, 200, "stop_sample_wait");
        check("stop_idle_with_sample", busy[0], 0);
        nbefore = req_n[0];
        run(1300);
        check("stop_no_more_requests", req_n[0] - nbefore, 0);
        pulse_start(0, 1'b1);
        run(10);
        check("start_stop_same_cycle", {busy[0], 31'(req_n[0] - nbefore)}, 0);

        // Asynchronous reset in the middle of a conversion.
        pulse_start(0, 1'b0);
        run(50);
        do_reset();
        check("reset_mid_conversion", {busy[0], en[0], sv[0]}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
